// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: scans a DIGITS-nibble value onto one seg7 decoder with one-hot digit enables,
//   optional leading-zero blanking and a tear-free value handshake (new values swap in at frame boundaries).
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   enable         1 = scan the display, 0 = dark (IDLE)
//   blank_leading  1 = blank leading zero digits (digit 0 never blanked)
//   value_in       nibble i = bits [4i+3:4i], digit 0 = LSD
//   value_valid    value_in offered; value_ready = pending slot empty
//   nibble         current nibble to the decoder (registered)
//   digit_en       one-hot enable of the lit digit, 0 when blanked/idle (registered)
//   blank          1 = segments off this cycle (registered)
module seg7_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  blank_leading,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  blank
);
    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       dwell_cnt, dwell_cnt_n;
    logic [IW-1:0]       digit_idx, digit_idx_n;
    logic [4*DIGITS-1:0] display_reg, display_n, pending_reg, pending_n;
    logic                pending_full, full_n;
    logic [3:0]          nibble_n;
    logic [DIGITS-1:0]   digit_en_n, lead_zero;
    logic                blank_n, xfer, last_dwell, frame_end, swap;

    assign value_ready = ~pending_full & ~reset;

    always_comb begin
        xfer        = value_valid & value_ready;
        last_dwell  = dwell_cnt == CW'(DWELL_CYCLES - 1);
        frame_end   = last_dwell && digit_idx == IW'(DIGITS - 1);
        // dropping enable wins over a coincident frame end; IDLE swaps on its first cycle anyway
        swap        = pending_full && (state == IDLE || (enable && frame_end));
        state_n     = enable ? SCAN : IDLE;
        dwell_cnt_n = dwell_cnt + 1'b1;
        digit_idx_n = digit_idx;
        if (state == IDLE || !enable) begin
            dwell_cnt_n = '0;
            digit_idx_n = '0;
        end else if (last_dwell) begin
            dwell_cnt_n = '0;
            digit_idx_n = frame_end ? '0 : digit_idx + 1'b1;
        end
        display_n    = swap ? pending_reg : display_reg;
        pending_n    = xfer ? value_in : pending_reg;
        full_n       = xfer | (pending_full & ~swap);
        lead_zero    = '0;
        for (int i = 1; i < DIGITS; i++)
            lead_zero[i] = blank_leading && (display_reg >> (4 * i)) == '0;
        nibble_n     = display_reg[{digit_idx, 2'b00} +: 4];
        blank_n      = state == IDLE || lead_zero[digit_idx];
        digit_en_n   = blank_n ? '0 : DIGITS'(1) << digit_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dwell_cnt    <= '0;
            digit_idx    <= '0;
            display_reg  <= '0;
            pending_reg  <= '0;
            pending_full <= 1'b0;
            nibble       <= '0;
            digit_en     <= '0;
            blank        <= 1'b1;
        end else begin
            state        <= state_n;
            dwell_cnt    <= dwell_cnt_n;
            digit_idx    <= digit_idx_n;
            display_reg  <= display_n;
            pending_reg  <= pending_n;
            pending_full <= full_n;
            nibble       <= nibble_n;
            digit_en     <= digit_en_n;
            blank        <= blank_n;
        end
    end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: scoreboard bench for seg7_scan_controller (DIGITS=4, DWELL_CYCLES=3);
//   a frame-position reference model predicts each cycle's outputs, a monitor compares them.
module tb_seg7_scan_controller;
    localparam int DIGITS = 4;
    localparam int DW     = 3;
    localparam int FRAME  = DIGITS * DW;

    logic                clk = 0;
    logic                reset = 1;
    logic                enable = 0;
    logic                blank_leading = 0;
    logic [4*DIGITS-1:0] value_in = '0;
    logic                value_valid = 0;
    logic                value_ready;
    logic [3:0]          nibble;
    logic [DIGITS-1:0]   digit_en;
    logic                blank;

    seg7_scan_controller #(.DIGITS(DIGITS), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .blank_leading(blank_leading),
        .value_in(value_in), .value_valid(value_valid), .value_ready(value_ready),
        .nibble(nibble), .digit_en(digit_en), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        nib;
        logic [DIGITS-1:0] en;
        logic              blk;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference model: scanning flag, position within the frame, shown value, 1-entry pending slot
    logic                m_scan = 0;
    int                  m_pos = 0;
    logic [4*DIGITS-1:0] m_show = '0;
    logic [4*DIGITS-1:0] m_pend = '0;
    logic                m_full = 0;

    always @(posedge clk) begin
        exp_t e;
        int   d;
        logic dark;
        if (reset) begin
            e = '{nib: 4'd0, en: '0, blk: 1'b1};
            m_scan <= 0;
            m_pos  <= 0;
            m_show <= '0;
            m_full <= 0;
        end else begin
            d     = m_pos / DW;
            dark  = !m_scan || (d > 0 && blank_leading && (m_show >> (4 * d)) == 0);
            e.nib = m_show[4*d +: 4];
            e.en  = dark ? '0 : DIGITS'(1) << d;
            e.blk = dark;
            if (!m_scan) begin
                if (m_full) begin
                    m_show <= m_pend;
                    m_full <= 0;
                end
                m_scan <= enable;
                m_pos  <= 0;
            end else if (!enable) begin
                m_scan <= 0;
                m_pos  <= 0;
            end else begin
                m_pos <= (m_pos == FRAME - 1) ? 0 : m_pos + 1;
                if (m_pos == FRAME - 1 && m_full) begin
                    m_show <= m_pend;
                    m_full <= 0;
                end
            end
            if (value_valid && !m_full) begin
                m_pend <= value_in;
                m_full <= 1;
            end
        end
        q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("nibble", 32'(nibble), 32'(e.nib));
            chk("digit_en", 32'(digit_en), 32'(e.en));
            chk("blank", 32'(blank), 32'(e.blk));
            chk("value_ready", 32'(value_ready), 32'(!m_full && !reset));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4*DIGITS-1:0] v);
        int t = 0;
        value_in    = v;
        value_valid = 1;
        @(negedge clk);
        while (!value_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!value_ready) begin
            failures++;
            $display("FAIL offer_timeout: value_ready stayed %b, required 1", value_ready);
        end
        @(posedge clk);
        #1;
        value_valid = 0;
    endtask

    task automatic wait_en(input logic [DIGITS-1:0] want);
        int t = 0;
        @(negedge clk);
        while (digit_en !== want && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (digit_en !== want) begin
            failures++;
            $display("FAIL wait_digit_en: got %b, required %b", digit_en, want);
        end
    endtask

    initial begin
        value_valid = 1;
        value_in    = 16'hFFFF;
        cycles(2);
        reset       = 0;
        value_valid = 0;
        cycles(2);
        offer(16'h1234);
        cycles(3);
        enable = 1;
        cycles(30);
        wait_en(4'b0010);
        offer(16'hABCD);
        cycles(30);
        blank_leading = 1;
        offer(16'h0050);
        cycles(30);
        offer(16'h0000);
        cycles(30);
        blank_leading = 0;
        offer(16'h9876);
        cycles(15);
        wait_en(4'b0100);
        enable = 0;
        cycles(5);
        enable = 1;
        cycles(30);
        for (int i = 0; i < 2000; i++) begin
            enable        = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 49) == 0) blank_leading = ~blank_leading;
            value_valid   = $urandom_range(0, 5) == 0;
            for (int k = 0; k < DIGITS; k++)
                value_in[4*k +: 4] = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
            reset         = i == 1000;
            cycles(1);
        end
        reset       = 0;
        value_valid = 0;
        cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
